issue_stage: RTL and testbench

Pipeline stage directly upstream of the execute stage. It accepts fetched instructions through a valid/ready handshake and buffers them in a 2-entry skid FIFO. It reads both source registers from the register file, with same-cycle forwarding from the execute stage. It holds one issue slot whose registered contents drive the execute stage. The slot holds while execute stalls, and all state is flushed on `clear`, which covers trap, mret and redirect.

---
 rtl/issue_stage_pkg.sv | 66 ++++++
 rtl/issue_stage_if.sv | 41 ++++
 rtl/issue_stage_fifo.sv | 66 ++++++
 rtl/issue_stage.sv | 84 ++++++++
 tb/tb_issue_stage.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_stage_pkg.sv
// Shared constants and types for the issue stage: opcode values, the FIFO entry,
// the issue-slot record, and the pre-decode and operand-select helpers.
package constants;
    localparam int issue_depth = 2;

    localparam logic [4:0] opcode_lui    = 5'b01101;
    localparam logic [4:0] opcode_auipc  = 5'b00101;
    localparam logic [4:0] opcode_jal    = 5'b11011;
    localparam logic [4:0] opcode_branch = 5'b11000;
    localparam logic [4:0] opcode_store  = 5'b01000;
    localparam logic [4:0] opcode_op     = 5'b01100;
endpackage

package wires;
    import constants::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        error;
    } issue_entry_type;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        error;
        logic [4:0]  waddr;
        logic        rden1;
        logic        rden2;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } issue_reg_type;

    localparam issue_reg_type init_issue_reg = '0;

    // Returns {rden1, rden2}; compressed encodings read no registers.
    function automatic logic [1:0] predecode(input logic [6:0] low7);
        logic [4:0] opcode;
        logic       rd1;
        logic       rd2;
        opcode = low7[6:2];
        rd1    = 1'b0;
        rd2    = 1'b0;
        if (low7[1:0] == 2'b11) begin
            rd1 = !(opcode == opcode_lui || opcode == opcode_auipc || opcode == opcode_jal);
            rd2 = (opcode == opcode_branch || opcode == opcode_store || opcode == opcode_op);
        end
        return {rd1, rd2};
    endfunction

    // x0 is never forwarded: a write to x0 must not leak its data into a reader.
    function automatic logic [31:0] capture_operand(
        input logic        rden,
        input logic [4:0]  rs,
        input logic        fwd_wren,
        input logic [4:0]  fwd_waddr,
        input logic [31:0] fwd_wdata,
        input logic [31:0] rf_rdata
    );
        if (!rden) return '0;
        if (fwd_wren && fwd_waddr == rs && rs != 5'd0) return fwd_wdata;
        if (rs == 5'd0) return '0;
        return rf_rdata;
    endfunction
endpackage

// File: rtl/issue_stage_if.sv
// Bundle between fetch / register file / execute and the issue stage.
// Handshake: an input transfer happens on a rising edge where in_valid and in_ready
// are both 1; once in_valid is raised, in_pc/in_instr/in_error stay stable until taken.
interface issue_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_error;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        fwd_wren;
    logic [4:0]  fwd_waddr;
    logic [31:0] fwd_wdata;
    logic        exe_stall;
    logic        iss_valid;
    logic [31:0] iss_pc;
    logic [31:0] iss_instr;
    logic        iss_error;
    logic [4:0]  iss_waddr;
    logic        iss_rden1;
    logic        iss_rden2;
    logic [31:0] iss_rdata1;
    logic [31:0] iss_rdata2;

    modport master (
        output in_valid, in_pc, in_instr, in_error, rf_rdata1, rf_rdata2,
               fwd_wren, fwd_waddr, fwd_wdata, exe_stall,
        input  in_ready, rf_raddr1, rf_raddr2, iss_valid, iss_pc, iss_instr,
               iss_error, iss_waddr, iss_rden1, iss_rden2, iss_rdata1, iss_rdata2
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_error, rf_rdata1, rf_rdata2,
               fwd_wren, fwd_waddr, fwd_wdata, exe_stall,
        output in_ready, rf_raddr1, rf_raddr2, iss_valid, iss_pc, iss_instr,
               iss_error, iss_waddr, iss_rden1, iss_rden2, iss_rdata1, iss_rdata2
    );
endinterface

// File: rtl/issue_stage_fifo.sv
// Two-entry skid buffer between fetch and the issue slot; full is registered so
// in_ready never depends combinationally on the execute stall.
module issue_fifo
    import wires::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic            push,
    input  issue_entry_type push_data,
    input  logic            pop,
    output issue_entry_type head,
    output logic            full,
    output logic            empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    issue_entry_type  mem_q [DEPTH];
    issue_entry_type  mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage is zeroed on reset so the register-file addresses read 0 out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
endmodule

// File: rtl/issue_stage.sv
// Issue stage: skid FIFO feeding one registered issue slot; operands are read from
// the FIFO head with same-cycle forwarding from execute, and captured on load.
module issue_stage
    import constants::*;
    import wires::*;
#(
    parameter int DEPTH = issue_depth
) (
    input logic         clock,
    input logic         reset,
    input logic         clear,
    issue_stage_if.slave bus
);
    issue_entry_type push_data;
    issue_entry_type head;
    issue_reg_type   slot_q, slot_d;
    logic            push, pop, full, empty, head_valid;
    logic [4:0]      rs1, rs2;
    logic [1:0]      rden;
    logic [31:0]     opnd1, opnd2;

    assign push_data  = '{pc: bus.in_pc, instr: bus.in_instr, error: bus.in_error};
    assign bus.in_ready = ~full;
    assign push       = bus.in_valid & ~full & ~clear;
    assign head_valid = ~empty;
    assign pop        = head_valid & (~slot_q.valid | ~bus.exe_stall) & ~clear;

    issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Sources are presented from the head every cycle, popped or not.
    assign rs1           = head.instr[19:15];
    assign rs2           = head.instr[24:20];
    assign bus.rf_raddr1 = rs1;
    assign bus.rf_raddr2 = rs2;
    assign rden          = predecode(head.instr[6:0]);
    assign opnd1 = capture_operand(rden[1], rs1, bus.fwd_wren, bus.fwd_waddr,
                                   bus.fwd_wdata, bus.rf_rdata1);
    assign opnd2 = capture_operand(rden[0], rs2, bus.fwd_wren, bus.fwd_waddr,
                                   bus.fwd_wdata, bus.rf_rdata2);

    always_comb begin
        slot_d = slot_q;
        if (clear) begin
            slot_d = init_issue_reg;
        end else if (pop) begin
            slot_d.valid  = 1'b1;
            slot_d.pc     = head.pc;
            slot_d.instr  = head.instr;
            slot_d.error  = head.error;
            slot_d.waddr  = head.instr[11:7];
            slot_d.rden1  = rden[1];
            slot_d.rden2  = rden[0];
            slot_d.rdata1 = opnd1;
            slot_d.rdata2 = opnd2;
        end else if (slot_q.valid && !bus.exe_stall) begin
            slot_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) slot_q <= init_issue_reg;
        else       slot_q <= slot_d;
    end

    assign bus.iss_valid  = slot_q.valid;
    assign bus.iss_pc     = slot_q.pc;
    assign bus.iss_instr  = slot_q.instr;
    assign bus.iss_error  = slot_q.error;
    assign bus.iss_waddr  = slot_q.waddr;
    assign bus.iss_rden1  = slot_q.rden1;
    assign bus.iss_rden2  = slot_q.rden2;
    assign bus.iss_rdata1 = slot_q.rdata1;
    assign bus.iss_rdata2 = slot_q.rdata2;
endmodule

// File: tb/tb_issue_stage.sv
// Bench for issue_stage: an in-order architectural model predicts each issued
// slot; a negedge monitor compares slots against the expected queue.
module tb_issue_stage;
    localparam int EW = 136;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;

    issue_stage_if bus ();

    issue_stage #(.DEPTH(2)) dut (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [31:0]   rf   [32];
    logic [31:0]   arch [32];
    logic [EW-1:0] exp_q [$];
    logic [EW-1:0] snap;
    logic [EW-1:0] mon_cur;
    logic [EW-1:0] mon_exp;
    bit            fresh = 1'b1;
    bit            flush_prev = 1'b0;
    bit            rf_seed = 1'b1;
    logic [31:0]   pc_ctr = '0;
    int            n_checks = 0;
    int            n_pass = 0;
    logic          wr_en = 1'b0;
    logic [4:0]    wr_addr = '0;
    logic [31:0]   wr_data = '0;

    function automatic logic [EW-1:0] pack(
        input logic [31:0] pc, input logic [31:0] instr, input logic err,
        input logic [4:0] waddr, input logic r1, input logic r2,
        input logic [31:0] d1, input logic [31:0] d2);
        return {pc, instr, err, waddr, r1, r2, d1, d2};
    endfunction

    // Result the execute stage produces for an instruction (arbitrary but fixed).
    function automatic logic [31:0] exec_result(
        input logic [31:0] pc, input logic [31:0] instr,
        input logic [31:0] a, input logic [31:0] b);
        if (instr[6:0] == 7'b0110111) return {instr[31:12], 12'h000};
        if (instr[6:0] == 7'b0010011) return a + {{20{instr[31]}}, instr[31:20]};
        return a + b + pc;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [4:0]  r1, r2, rd, i5;
        logic [11:0] i12;
        logic [19:0] i20;
        logic [15:0] c16;
        logic [31:0] w;
        r1  = 5'($urandom_range(0, 3));
        r2  = 5'($urandom_range(0, 3));
        rd  = 5'($urandom_range(0, 3));
        i5  = 5'($urandom_range(0, 31));
        i12 = 12'($urandom_range(0, 4095));
        i20 = 20'($urandom);
        c16 = 16'($urandom);
        c16[1:0] = 2'($urandom_range(0, 2));
        case ($urandom_range(0, 8))
            0: w = {i12, r1, 3'b000, rd, 7'b0010011};
            1: w = {7'b0, r2, r1, 3'b000, rd, 7'b0110011};
            2: w = {i20, rd, 7'b0110111};
            3: w = {i20, rd, 7'b0010111};
            4: w = {i20, rd, 7'b1101111};
            5: w = {7'b0, r2, r1, 3'b010, i5, 7'b0100011};
            6: w = {7'b0, r2, r1, 3'b000, i5, 7'b1100011};
            7: w = {16'h0000, c16};
            default: w = $urandom;
        endcase
        return w;
    endfunction

    // Register file and execute stage as seen by the DUT.
    always_comb begin
        bus.rf_rdata1 = rf[bus.rf_raddr1];
        bus.rf_rdata2 = rf[bus.rf_raddr2];
    end

    always_comb begin
        bus.fwd_wren  = bus.iss_valid;
        bus.fwd_waddr = bus.iss_waddr;
        bus.fwd_wdata = (bus.iss_waddr == 5'd0) ? 32'hDEADBEEF :
                        exec_result(bus.iss_pc, bus.iss_instr, bus.iss_rdata1, bus.iss_rdata2);
    end

    always @(negedge clock) begin
        wr_en   <= bus.iss_valid && !bus.exe_stall && !clear && !reset && bus.iss_waddr != 5'd0;
        wr_addr <= bus.iss_waddr;
        wr_data <= bus.fwd_wdata;
    end

    always @(posedge clock) begin
        if (rf_seed) begin
            for (int i = 0; i < 32; i++) rf[i] <= (i < 3) ? 32'h0 : 32'h1000_0000 + 32'(i);
            rf_seed <= 1'b0;
        end else if (wr_en) begin
            rf[wr_addr] <= wr_data;
        end
    end

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // In-order reference: operands are the architectural values in program order.
    task automatic model_push(input logic [31:0] pc, input logic [31:0] instr, input logic err);
        logic        full_enc, r1, r2;
        logic [4:0]  op, rs1, rs2, rd;
        logic [31:0] d1, d2;
        full_enc = (instr[1:0] == 2'b11);
        op  = instr[6:2];
        rs1 = instr[19:15];
        rs2 = instr[24:20];
        rd  = instr[11:7];
        r1  = full_enc && !(op == 5'b01101 || op == 5'b00101 || op == 5'b11011);
        r2  = full_enc && (op == 5'b11000 || op == 5'b01000 || op == 5'b01100);
        d1  = (r1 && rs1 != 5'd0) ? arch[rs1] : 32'h0;
        d2  = (r2 && rs2 != 5'd0) ? arch[rs2] : 32'h0;
        if (rd != 5'd0) arch[rd] = exec_result(pc, instr, d1, d2);
        exp_q.push_back(pack(pc, instr, err, rd, r1, r2, d1, d2));
    endtask

    task automatic step(input logic v, input logic [31:0] instr, input logic err,
                        input logic stall, input logic clr, input logic rst, output bit acc);
        @(posedge clock);
        #2;
        if (flush_prev) for (int i = 0; i < 32; i++) arch[i] = rf[i];
        bus.in_valid  = v;
        bus.in_instr  = instr;
        bus.in_pc     = pc_ctr;
        bus.in_error  = err;
        bus.exe_stall = stall;
        clear         = clr;
        reset         = rst;
        acc = v && bus.in_ready && !clr && !rst;
        if (acc) begin
            model_push(pc_ctr, instr, err);
            pc_ctr += 32'd4;
        end
        flush_prev = clr || rst;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_slot"}, {bus.iss_valid, pack(bus.iss_pc, bus.iss_instr, bus.iss_error,
              bus.iss_waddr, bus.iss_rden1, bus.iss_rden2, bus.iss_rdata1, bus.iss_rdata2)}, '0);
        check({tag, "_raddr"}, EW'({bus.rf_raddr1, bus.rf_raddr2}), '0);
        check({tag, "_in_ready"}, EW'(bus.in_ready), EW'(1));
    endtask

    // Monitor: a freshly loaded slot pops the next expectation; a stalled slot must hold.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            fresh = 1'b1;
        end else begin
            if (bus.iss_valid) begin
                mon_cur = pack(bus.iss_pc, bus.iss_instr, bus.iss_error, bus.iss_waddr,
                               bus.iss_rden1, bus.iss_rden2, bus.iss_rdata1, bus.iss_rdata2);
                if (fresh) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL slot_unexpected: got %h expected no instruction", mon_cur);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("slot", mon_cur, mon_exp);
                    end
                    snap = mon_cur;
                end else begin
                    check("slot_hold", mon_cur, snap);
                end
            end
            fresh = !(bus.iss_valid && bus.exe_stall);
            if (clear) begin
                exp_q.delete();
                fresh = 1'b1;
            end
        end
    end

    initial begin
        bit          acc;
        int          sent;
        bit          have;
        logic [31:0] cur_instr;
        logic        cur_err;
        logic [31:0] burst [4];

        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_instr  = '0;
        bus.in_error  = 1'b0;
        bus.exe_stall = 1'b0;

        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        idle(1);
        @(negedge clock);
        check_reset_values("reset");

        // Back-to-back dependent addi pair; second operand comes off the forward bus.
        step(1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00108113, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        idle(1);
        @(negedge clock);
        check("lat_first", EW'({bus.iss_valid, bus.iss_pc}), EW'({1'b1, 32'h0}));
        check("head_raddr1", EW'(bus.rf_raddr1), EW'(5'd1));
        idle(1);
        @(negedge clock);
        check("lat_second", EW'({bus.iss_valid, bus.iss_pc}), EW'({1'b1, 32'h4}));
        check("fwd_rdata1", EW'(bus.iss_rdata1), EW'(32'd5));

        // Write to x0 followed by a reader of x0.
        step(1'b1, 32'h00700013, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00100193, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        idle(2);
        @(negedge clock);
        check("x0_rdata1", EW'({bus.iss_valid, bus.iss_rdata1}), EW'({1'b1, 32'h0}));

        // LUI then compressed: neither reads sources.
        step(1'b1, 32'h123450B7, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00004501, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        idle(1);
        @(negedge clock);
        check("lui_rden", EW'({bus.iss_instr, bus.iss_rden1, bus.iss_rden2}), EW'({32'h123450B7, 2'b00}));
        check("lui_rdata", EW'({bus.iss_rdata1, bus.iss_rdata2}), '0);
        idle(1);
        @(negedge clock);
        check("c_rden", EW'({bus.iss_instr, bus.iss_error, bus.iss_rden1, bus.iss_rden2}),
              EW'({32'h00004501, 1'b1, 2'b00}));
        idle(3);

        // Stall burst: four offered, execute stalled for the first cycles.
        for (int i = 0; i < 4; i++) burst[i] = gen_instr();
        sent = 0;
        for (int k = 0; k < 30 && sent < 4; k++) begin
            step(1'b1, burst[sent], 1'b0, k < 5, 1'b0, 1'b0, acc);
            if (k == 3) check("stall_in_ready", EW'(bus.in_ready), '0);
            if (acc) sent++;
        end
        check("stall_all_sent", EW'(sent), EW'(4));
        idle(5);

        // Clear with FIFO full, slot valid and an instruction offered.
        for (int i = 0; i < 3; i++) step(1'b1, gen_instr(), 1'b0, 1'b1, 1'b0, 1'b0, acc);
        step(1'b1, gen_instr(), 1'b0, 1'b1, 1'b1, 1'b0, acc);
        idle(1);
        @(negedge clock);
        check("clear_state", EW'({bus.iss_valid, bus.in_ready}), EW'(2'b01));
        step(1'b1, 32'h00500093, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        idle(3);
        @(negedge clock);
        check("clear_drop", EW'(bus.iss_valid), '0);

        // Randomized traffic with stalls and occasional clears.
        have = 1'b0;
        cur_instr = '0;
        cur_err = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (!have) begin
                cur_instr = gen_instr();
                cur_err   = ($urandom_range(0, 15) == 0);
                have      = ($urandom_range(0, 3) != 0);
            end
            step(have, cur_instr, cur_err, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 3, 1'b0, acc);
            if (acc || clear) have = 1'b0;
        end
        idle(10);
        check("drain_empty", EW'(exp_q.size()), '0);

        // Reset in the middle of a stalled burst.
        for (int i = 0; i < 3; i++) step(1'b1, gen_instr(), 1'b0, 1'b1, 1'b0, 1'b0, acc);
        step(1'b1, gen_instr(), 1'b0, 1'b1, 1'b0, 1'b1, acc);
        idle(1);
        @(negedge clock);
        check_reset_values("midreset");
        step(1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        idle(4);
        check("final_empty", EW'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
